// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-stage definitions: memory geometry, reset/halt constants and the sequencer states.
// Imported by fetch_ctrl, i_mem and the decode stage so they agree on widths and encodings.
package fetch_ctrl_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  localparam logic [ADDR_W-1:0] RESET_PC  = 8'h00;
  localparam logic [DATA_W-1:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl_slot.sv
// One-entry valid/ready pipeline register carrying a data word and its address.
// Flush beats load, load beats a plain accept; contents hold while valid and not accepted.
module fetch_ctrl_slot #(
  parameter int DATA_W = fetch_ctrl_pkg::DATA_W,
  parameter int ADDR_W = fetch_ctrl_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              flush,
  input  logic [DATA_W-1:0] load_data,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] pc,
  output logic              accept,
  output logic              free
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] pc_q;

  assign accept = valid_q & ready;
  assign free   = ~valid_q | accept;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= load_data;
      pc_q    <= load_pc;
    end else if (accept) begin
      valid_q <= 1'b0;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign pc    = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, addresses the zero-latency i_mem and feeds
// fetched words into a one-entry output slot, handling start, halt words, redirects and stalls.
module fetch_ctrl #(
  parameter int                        ADDR_W    = fetch_ctrl_pkg::ADDR_W,
  parameter int                        DATA_W    = fetch_ctrl_pkg::DATA_W,
  parameter int                        CNT_W     = fetch_ctrl_pkg::CNT_W,
  parameter logic [ADDR_W-1:0]         RESET_PC  = fetch_ctrl_pkg::RESET_PC,
  parameter logic [DATA_W-1:0]         HALT_WORD = fetch_ctrl_pkg::HALT_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);

  import fetch_ctrl_pkg::*;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  count_q;
  logic              slot_load, slot_flush;
  logic              slot_accept, slot_free;

  fetch_ctrl_slot #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (slot_load),
    .flush     (slot_flush),
    .load_data (imem_data),
    .load_pc   (pc_q),
    .ready     (instr_ready),
    .valid     (instr_valid),
    .data      (instr),
    .pc        (instr_pc),
    .accept    (slot_accept),
    .free      (slot_free)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    slot_load  = 1'b0;
    slot_flush = 1'b0;

    if (redirect_valid) begin
      pc_d       = redirect_pc;
      slot_flush = 1'b1;
      state_d    = ST_FETCH;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) state_d = ST_FETCH;
        end
        ST_FETCH: begin
          // A halt word is never delivered; pc parks on it so restart can step past it.
          if (slot_free) begin
            if (imem_data != HALT_WORD) begin
              slot_load = 1'b1;
              pc_d      = pc_q + 1'b1;
            end else begin
              state_d = ST_HALTED;
            end
          end
        end
        ST_HALTED: begin
          if (start) begin
            state_d = ST_FETCH;
            pc_d    = pc_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // An instruction flushed by a redirect in the same cycle is not counted as delivered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (slot_accept && !redirect_valid && count_q != {CNT_W{1'b1}}) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign imem_addr   = pc_q;
  assign halted      = (state_q == ST_HALTED);
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: stimulus pushes expected (pc, word) deliveries,
// a negedge monitor pops and compares every accepted instruction.
module tb_fetch_ctrl;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
  localparam logic [DATA_W-1:0] HALT = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] word;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              halted;
  logic [CNT_W-1:0]  fetch_count;

  logic [DATA_W-1:0] mem [256];
  exp_t              sb_q[$];
  int                n_checks = 0;
  int                n_errors = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [ADDR_W-1:0] pc, input logic [DATA_W-1:0] word);
    exp_t e;
    e.pc   = pc;
    e.word = word;
    sb_q.push_back(e);
  endtask

  // Monitor: a delivery is an accept that is not flushed by a same-cycle redirect.
  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready && !redirect_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_delivery_pc", {24'd0, instr_pc}, 32'hDEAD_0000);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("deliver_pc", {24'd0, instr_pc}, {24'd0, e.pc});
        check("deliver_word", instr, e.word);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;
    mem[0] = 32'h0000_0000; mem[1] = 32'h0016_8033;
    mem[2] = 32'h0016_8032; mem[3] = 32'h0016_8031;
    mem[4] = 32'h0000_0000; mem[5] = 32'h0016_8033;
    mem[6] = 32'h0016_8032; mem[7] = 32'h0016_8031;

    rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    tick(); tick();
    check("reset_valid", {31'd0, instr_valid}, 32'd0);
    check("reset_instr", instr, 32'd0);
    check("reset_instr_pc", {24'd0, instr_pc}, 32'd0);
    check("reset_halted", {31'd0, halted}, 32'd0);
    check("reset_count", {16'd0, fetch_count}, 32'd0);
    check("reset_addr", {24'd0, imem_addr}, 32'd0);

    // Sequential fetch from 0.
    rst_n = 1'b1; instr_ready = 1'b1;
    tick();
    check("idle_no_fetch", {31'd0, instr_valid}, 32'd0);
    push(8'd0, 32'h0000_0000); push(8'd1, 32'h0016_8033); push(8'd2, 32'h0016_8032);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_cycle_no_fetch", {31'd0, instr_valid}, 32'd0);
    tick(); tick(); tick();
    // Stall with pc 2 in the slot.
    check("pre_stall_pc", {24'd0, instr_pc}, 32'd2);
    instr_ready = 1'b0;
    check("pre_stall_count", {16'd0, fetch_count}, 32'd2);
    tick(); tick();
    check("stall_instr", instr, 32'h0016_8032);
    check("stall_instr_pc", {24'd0, instr_pc}, 32'd2);
    check("stall_addr", {24'd0, imem_addr}, 32'd3);
    check("stall_count", {16'd0, fetch_count}, 32'd2);
    instr_ready = 1'b1;
    tick();
    check("resume_pc", {24'd0, instr_pc}, 32'd3);

    // Redirect to 6 while pc 3 is being accepted: pc 3 must be flushed, not counted.
    redirect_valid = 1'b1; redirect_pc = 8'd6;
    tick();
    redirect_valid = 1'b0;
    check("redirect_flush_valid", {31'd0, instr_valid}, 32'd0);
    check("redirect_count", {16'd0, fetch_count}, 32'd3);
    check("redirect_addr", {24'd0, imem_addr}, 32'd6);
    push(8'd6, 32'h0016_8032); push(8'd7, 32'h0016_8031);
    tick(); tick(); tick();

    // Halt word at 5, reached via redirect to 4.
    mem[5] = HALT;
    redirect_valid = 1'b1; redirect_pc = 8'd4;
    tick();
    redirect_valid = 1'b0;
    check("pre_halt_count", {16'd0, fetch_count}, 32'd5);
    push(8'd4, 32'h0000_0000);
    tick();
    check("addr_halt_word", {24'd0, imem_addr}, 32'd5);
    check("not_yet_halted", {31'd0, halted}, 32'd0);
    tick();
    check("halted", {31'd0, halted}, 32'd1);
    check("halt_pc", {24'd0, imem_addr}, 32'd5);
    check("halt_slot_empty", {31'd0, instr_valid}, 32'd0);
    tick();
    check("halt_hold", {31'd0, halted}, 32'd1);
    check("halt_count", {16'd0, fetch_count}, 32'd6);
    push(8'd6, 32'h0016_8032);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_not_halted", {31'd0, halted}, 32'd0);
    check("restart_addr", {24'd0, imem_addr}, 32'd6);
    tick(); tick();

    // Wrap-around: FE, FF, 00, 01.
    redirect_valid = 1'b1; redirect_pc = 8'hFE;
    tick();
    redirect_valid = 1'b0;
    check("pre_wrap_count", {16'd0, fetch_count}, 32'd7);
    push(8'hFE, 32'hA000_00FE); push(8'hFF, 32'hA000_00FF);
    push(8'h00, 32'h0000_0000); push(8'h01, 32'h0016_8033);
    tick(); tick(); tick(); tick(); tick();
    check("wrap_count", {16'd0, fetch_count}, 32'd11);
    check("pre_reset_valid", {31'd0, instr_valid}, 32'd1);

    // Mid-run reset with a full slot.
    instr_ready = 1'b0; rst_n = 1'b0;
    tick();
    check("midreset_valid", {31'd0, instr_valid}, 32'd0);
    check("midreset_addr", {24'd0, imem_addr}, 32'd0);
    check("midreset_count", {16'd0, fetch_count}, 32'd0);
    check("midreset_halted", {31'd0, halted}, 32'd0);
    rst_n = 1'b1; instr_ready = 1'b1;
    tick(); tick();
    check("post_reset_idle", {31'd0, instr_valid}, 32'd0);
    check("post_reset_addr", {24'd0, imem_addr}, 32'd0);
    push(8'd0, 32'h0000_0000);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    instr_ready = 1'b0;
    tick();
    check("final_count", {16'd0, fetch_count}, 32'd1);

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
    check("scoreboard_drained", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
